// File: rtl/gold_nic_fifo_pkg.sv
// Shared constants for the gold NIC FIFO slice: register map, status
// word layout and a constant-evaluable clog2 for sizing pointers/counts.
package gold_nic_pkg;

  // Core-side register map (2-bit addr)
  localparam logic [1:0] ADDR_OUT_DATA = 2'b00;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b01;
  localparam logic [1:0] ADDR_IN_DATA  = 2'b10;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b11;

  // Status word layout, in numeric (LSB = 0) bit positions.
  // The flag (full / not-empty) is the LSB; the count sits right above it.
  localparam int STAT_FLAG_BIT = 0;
  // The sticky overflow flag lives STAT_OVF_BIT positions below the word
  // width, i.e. at numeric bit DATA_W-2.
  localparam int STAT_OVF_BIT  = 2;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/gold_nic_fifo_sync.sv
// Synchronous FIFO used for both NIC directions. Pushes into a full FIFO
// and pops from an empty one are ignored; head is the raw storage word at
// the read pointer and is only meaningful while !empty.
module nic_sync_fifo
  import gold_nic_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [0:WIDTH-1]        din,
  output logic [0:WIDTH-1]        head,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [0:WIDTH-1] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write at the tail.
  // NOTE: the data array has no reset; pointers and count define validity,
  // and leaving it unreset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gold_nic_fifo.sv
// Gold NIC with per-direction FIFOs between the core memory stage and a
// ring router port. Core side: 2-bit register interface, one-cycle read
// latency. Ring side: ready/send handshake with the polarity-aware send
// rule (head leaves only when router polarity != head VC bit).
// Optional: `define NIC_OVERFLOW_STICKY_EN adds a sticky overflow flag at
// status bit DATA_W-2, set by core writes to a full output FIFO and
// cleared by an addr-01 status read.
module gold_nic_fifo
  import gold_nic_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4,
  parameter int VC_BIT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicEnWr,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  localparam int OCW = clog2(OUT_DEPTH) + 1;
  localparam int ICW = clog2(IN_DEPTH) + 1;

  logic [0:DATA_W-1] out_head;
  logic [OCW-1:0]    out_count;
  logic              out_full;
  logic              out_empty;
  logic [0:DATA_W-1] in_head;
  logic [ICW-1:0]    in_count;
  logic              in_full;
  logic              in_empty;

  logic              out_push;
  logic              rd_req;
  logic              in_pop;
  logic [DATA_W-1:0] out_stat;
  logic [DATA_W-1:0] in_stat;

  logic [1:0]        addr_q;
  logic              en_q;
  logic              wr_q;
  logic [0:DATA_W-1] rd_q;
  logic [0:DATA_W-1] stat_q;

  assign out_push = nicEn && nicEnWr && (addr == ADDR_OUT_DATA);
  assign rd_req   = nicEn && !nicEnWr;
  assign in_pop   = rd_req && (addr == ADDR_IN_DATA);

  assign net_so = !out_empty && net_ro && (net_polarity != out_head[VC_BIT]);
  assign net_do = out_empty ? '0 : out_head;
  assign net_ri = !in_full;

  nic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (net_so),
    .din   (d_in),
    .head  (out_head),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  nic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (net_si && net_ri),
    .pop   (in_pop),
    .din   (net_di),
    .head  (in_head),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

`ifdef NIC_OVERFLOW_STICKY_EN
  logic ovf_q;

  // Sticky overflow: a dropped core write sets it; an out-status read clears it (set wins).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (out_push && out_full) begin
      ovf_q <= 1'b1;
    end else if (rd_req && (addr == ADDR_OUT_STAT)) begin
      ovf_q <= 1'b0;
    end
  end
`endif

  // Status words as seen before the request edge.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    out_stat                            = '0;
    out_stat[STAT_FLAG_BIT]             = out_full;
    out_stat[STAT_FLAG_BIT+1 +: OCW]    = out_count;
`ifdef NIC_OVERFLOW_STICKY_EN
    out_stat[DATA_W-STAT_OVF_BIT]       = ovf_q;
`else
    out_stat[DATA_W-STAT_OVF_BIT]       = 1'b0;
`endif
    in_stat                             = '0;
    in_stat[STAT_FLAG_BIT]              = !in_empty;
    in_stat[STAT_FLAG_BIT+1 +: ICW]     = in_count;
  end

  // Capture the request and the word it returns; presented one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      en_q   <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= '0;
      stat_q <= '0;
    end else begin
      addr_q <= addr;
      en_q   <= nicEn;
      wr_q   <= nicEnWr;
      if (in_pop) rd_q <= in_empty ? '0 : in_head;
      if (rd_req && (addr == ADDR_OUT_STAT))     stat_q <= out_stat;
      else if (rd_req && (addr == ADDR_IN_STAT)) stat_q <= in_stat;
    end
  end

  // Read mux driven by the registered request.
  always_comb begin
    d_out = '0;
    if (en_q && !wr_q) begin
      case (addr_q)
        ADDR_IN_DATA:               d_out = rd_q;
        ADDR_OUT_STAT, ADDR_IN_STAT: d_out = stat_q;
        default:                    d_out = '0;
      endcase
    end
  end

endmodule

// File: doc/gold_nic_fifo.md
Name: gold_nic_fifo

Overview:
- Parametrised successor to the single-entry gold NIC: processor-side 2-bit register interface, ring-side ready/send handshake, per-channel FIFOs of configurable depth replacing the one-word buffers.
- Sits between the core's memory stage and the ring router port.
- Keeps the polarity-aware send rule: the head packet departs only when the router's polarity differs from the packet's VC bit.

Parameters:
- DATA_W, 64: flit width; all data ports use [0:DATA_W-1], bit 0 is MSB.
- OUT_DEPTH, 4: output (core-to-ring) FIFO entries; power of 2, >=2.
- IN_DEPTH, 4: input (ring-to-core) FIFO entries; power of 2, >=2.
- VC_BIT, 0: index of the virtual-channel/polarity bit inside a flit.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  2  register select: 00 out-data, 01 out-status, 10 in-data, 11 in-status.
- d_in  in  DATA_W  core write data.
- d_out  out  DATA_W  core read data, one-cycle latency.
- nicEn  in  1  access enable.
- nicEnWr  in  1  1 = write, 0 = read (qualified by nicEn).
- net_si  in  1  ring offers a flit.
- net_ri  out  1  NIC can accept a flit.
- net_di  in  DATA_W  ring flit in.
- net_so  out  1  NIC sends a flit this cycle.
- net_ro  in  1  router can accept a flit.
- net_do  out  DATA_W  flit out (output FIFO head).
- net_polarity  in  1  router's current polarity.

Behaviour:
- Reset (reset=0, async): both FIFOs empty (pointers and counts 0); read register 0; d_out=0, net_do=0, net_so=0, net_ri=1.
- Output push: nicEn & nicEnWr & addr==00 & out not full. d_in is written at the tail at the clock edge. A write to a full FIFO is ignored (dropped).
- Output pop: net_so = out_count!=0 & net_ro & (net_polarity != head[VC_BIT]). Pop occurs at the same edge.
- net_do: combinational head of the output FIFO; 0 when empty.
- Simultaneous push and pop on the output FIFO: count unchanged. Full plus pop in the same cycle still rejects the push; full is evaluated pre-edge.
- Input push: net_si & net_ri, where net_ri = in_count != IN_DEPTH. A push while full cannot occur, because net_ri=0 then.
- Input pop: nicEn & !nicEnWr & addr==10 & in not empty. The head is latched into the read register and popped. A read while empty latches 0.
- Simultaneous push and pop on the input FIFO: both occur, count unchanged. On an empty FIFO, the pushed word is not visible to a same-cycle read.
- d_out is driven from registered addr/nicEn/nicEnWr (one cycle after the request):
  - 0 if the registered nicEn=0 or the registered nicEnWr=1.
  - addr 00: 0.
  - addr 01: LSB = out full; bits above carry out_count, zero-extended.
  - addr 10: read register.
  - addr 11: LSB = in not-empty; bits above carry in_count.
- Pointers wrap modulo depth. Counts are clog2(depth)+1 bits wide.
- Reset mid-operation discards all queued flits. net_so drops the same cycle reset asserts.

Optional Feature:
- Macro: NIC_OVERFLOW_STICKY_EN.
- With it: a sticky overflow flag is set when the core writes addr 00 while the output FIFO is full.
  - The flag appears at bit DATA_W-2 of the addr-01 status read.
  - It is cleared by a status read at addr 01; a set in the same cycle as the clear wins.
- Without it: bit DATA_W-2 of the status read reads 0 and there is no extra flop.

Decomposition:
- Package gold_nic_pkg holds:
  - address localparams ADDR_OUT_DATA/ADDR_OUT_STAT/ADDR_IN_DATA/ADDR_IN_STAT;
  - status bit positions STAT_FLAG_BIT and STAT_OVF_BIT;
  - a clog2 function.
- One sub-module, nic_sync_fifo (params WIDTH, DEPTH; push, pop, din, head, count, full, empty), instantiated twice.

Test Plan:
- Reset, then read addr 01 and addr 11 -> d_out=0 each cycle after; net_ri=1, net_so=0.
- Core writes 0x1..0x4 with DEPTH 4, net_ro=0 -> status=0x9 (count 4, full); 5th write 0x5 dropped. Then net_ro=1, net_polarity=1 -> net_so for 4 cycles, net_do 0x1..0x4.
- Head with bit 0 = 1, net_polarity=1, net_ro=1 -> net_so=0. Toggle net_polarity to 0 -> net_so=1 that cycle.
- Ring pushes 4 flits -> net_ri=0. Core reads addr 10 four times -> d_out = flits in order, one cycle after each read. A 5th read returns 0.
- Input FIFO with 1 entry; push and pop in the same cycle -> count stays 1, d_out = old head.
- NIC_OVERFLOW_STICKY_EN: write to full FIFO, read 01 -> bit DATA_W-2 = 1; read 01 again -> 0.
